// File: rtl/sdram_client_arbiter.sv
`default_nettype none
// ============================================================================
// sdram_client_arbiter : N-client arbiter (round-robin / fixed priority) in
// front of SDRAMBus, one outstanding access, per-access watchdog.   Rev 1.0
// ============================================================================
module sdram_client_arbiter #(
    parameter int N_CLIENTS   = 5,
    parameter int AW          = 23,
    parameter int DW          = 32,
    parameter int RR_MODE     = 1,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_CLIENTS-1:0]    cli_read,
    input  logic [N_CLIENTS-1:0]    cli_write,
    input  logic [N_CLIENTS*AW-1:0] cli_addr,
    input  logic [N_CLIENTS*DW-1:0] cli_writedata,
    output logic [DW-1:0]           cli_readdata,
    output logic [N_CLIENTS-1:0]    cli_finished,
    output logic [N_CLIENTS-1:0]    cli_error,
    output logic [AW-1:0]           sdram_addr,
    output logic                    sdram_read,
    output logic                    sdram_write,
    output logic [DW-1:0]           sdram_writedata,
    input  logic [DW-1:0]           sdram_readdata,
    input  logic                    sdram_finished,
    output logic [N_CLIENTS-1:0]    o_grant,
    output logic                    o_busy
);
    localparam int IW  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WDW-1:0] C_WD_LAST = WDW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_BUSY = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic                 rd_q, rd_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic [N_CLIENTS-1:0] grant_q, grant_d;
    logic [N_CLIENTS-1:0] fin_q, fin_d;
    logic [N_CLIENTS-1:0] err_q, err_d;
    logic                 sread_q, sread_d;
    logic                 swrite_q, swrite_d;
    logic                 busy_q, busy_d;
    logic [WDW-1:0]       wdog_q, wdog_d;

    logic [N_CLIENTS-1:0] req;
    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic [IW-1:0]        cand;
    logic                 win_rd;
    logic [AW-1:0]        win_addr;
    logic [DW-1:0]        win_wdata;
    logic                 wd_expire;

    // Descending scan with overwrite leaves the first requester after the pointer
    // (round-robin) or the lowest requester (fixed priority) as the winner.
    always_comb begin
        req       = cli_read | cli_write;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = N_CLIENTS; i >= 1; i--) begin
            if (RR_MODE != 0)
                cand = IW'((int'(ptr_q) + i) % N_CLIENTS);
            else
                cand = IW'(i - 1);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_rd    = cli_read[win_idx];
        win_addr  = cli_addr[int'(win_idx)*AW +: AW];
        win_wdata = cli_writedata[int'(win_idx)*DW +: DW];
    end

    assign wd_expire = (TIMEOUT_CYC != 0) && (wdog_q == C_WD_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= C_ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: if (win_found) state_d = C_ST_BUSY;
            C_ST_BUSY: if (sdram_finished || wd_expire) state_d = C_ST_DONE;
            C_ST_DONE: state_d = C_ST_IDLE;
            default:   state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        grant_d  = grant_q;
        fin_d    = '0;
        err_d    = '0;
        sread_d  = sread_q;
        swrite_d = swrite_q;
        wdog_d   = wdog_q;
        busy_d   = (state_d != C_ST_IDLE);
        case (state_q)
            C_ST_IDLE: begin
                sread_d  = 1'b0;
                swrite_d = 1'b0;
                if (win_found) begin
                    gidx_d           = win_idx;
                    rd_d             = win_rd;
                    addr_d           = win_addr;
                    wdata_d          = win_wdata;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    // read has precedence when a client raises both strobes
                    sread_d          = win_rd;
                    swrite_d         = ~win_rd;
                    wdog_d           = '0;
                end
            end
            C_ST_BUSY: begin
                if (sdram_finished) begin
                    sread_d  = 1'b0;
                    swrite_d = 1'b0;
                    fin_d    = grant_q;
                    if (rd_q) rdata_d = sdram_readdata;
                end else if (wd_expire) begin
                    sread_d  = 1'b0;
                    swrite_d = 1'b0;
                    fin_d    = grant_q;
                    err_d    = grant_q;
                    if (rd_q) rdata_d = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            C_ST_DONE: begin
                grant_d = '0;
                if (RR_MODE != 0) ptr_d = gidx_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q    <= IW'(N_CLIENTS - 1);
            gidx_q   <= '0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            grant_q  <= '0;
            fin_q    <= '0;
            err_q    <= '0;
            sread_q  <= 1'b0;
            swrite_q <= 1'b0;
            busy_q   <= 1'b0;
            wdog_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            grant_q  <= grant_d;
            fin_q    <= fin_d;
            err_q    <= err_d;
            sread_q  <= sread_d;
            swrite_q <= swrite_d;
            busy_q   <= busy_d;
            wdog_q   <= wdog_d;
        end
    end

    assign cli_readdata    = rdata_q;
    assign cli_finished    = fin_q;
    assign cli_error       = err_q;
    assign sdram_addr      = addr_q;
    assign sdram_read      = sread_q;
    assign sdram_write     = swrite_q;
    assign sdram_writedata = wdata_q;
    assign o_grant         = grant_q;
    assign o_busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_client_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sdram_client_arbiter : directed bench, round-robin DUT (a_*) and
// fixed-priority DUT (b_*), each with a latency-programmable SDRAM model.  Rev 1.0
// ============================================================================
module tb_sdram_client_arbiter;
    localparam int N  = 5;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int TO = 16;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    logic [N-1:0]    a_read, a_write, a_fin, a_err, a_grant;
    logic [N*AW-1:0] a_addr;
    logic [N*DW-1:0] a_wdata;
    logic [DW-1:0]   a_rdata, a_sd_wdata, a_sd_rdata;
    logic [AW-1:0]   a_sd_addr;
    logic            a_sd_read, a_sd_write, a_busy;
    logic            a_sd_fin = 1'b0;

    logic [N-1:0]    b_read, b_write, b_fin, b_err, b_grant;
    logic [N*AW-1:0] b_addr;
    logic [N*DW-1:0] b_wdata;
    logic [DW-1:0]   b_rdata, b_sd_wdata;
    logic [DW-1:0]   b_sd_rdata = 32'h0BAD_F00D;
    logic [AW-1:0]   b_sd_addr;
    logic            b_sd_read, b_sd_write, b_busy;
    logic            b_sd_fin = 1'b0;

    sdram_client_arbiter #(.N_CLIENTS(N), .AW(AW), .DW(DW), .RR_MODE(1), .TIMEOUT_CYC(TO)) dut_a (
        .i_clk(i_clk), .i_rst(i_rst),
        .cli_read(a_read), .cli_write(a_write), .cli_addr(a_addr), .cli_writedata(a_wdata),
        .cli_readdata(a_rdata), .cli_finished(a_fin), .cli_error(a_err),
        .sdram_addr(a_sd_addr), .sdram_read(a_sd_read), .sdram_write(a_sd_write),
        .sdram_writedata(a_sd_wdata), .sdram_readdata(a_sd_rdata), .sdram_finished(a_sd_fin),
        .o_grant(a_grant), .o_busy(a_busy)
    );

    sdram_client_arbiter #(.N_CLIENTS(N), .AW(AW), .DW(DW), .RR_MODE(0), .TIMEOUT_CYC(TO)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst),
        .cli_read(b_read), .cli_write(b_write), .cli_addr(b_addr), .cli_writedata(b_wdata),
        .cli_readdata(b_rdata), .cli_finished(b_fin), .cli_error(b_err),
        .sdram_addr(b_sd_addr), .sdram_read(b_sd_read), .sdram_write(b_sd_write),
        .sdram_writedata(b_sd_wdata), .sdram_readdata(b_sd_rdata), .sdram_finished(b_sd_fin),
        .o_grant(b_grant), .o_busy(b_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // SDRAM models: finished pulses on the lat-th cycle of a held strobe; lat=0 never answers
    int lat_a = 5;
    int lat_b = 4;
    int cnt_a = 0;
    int cnt_b = 0;
    always @(negedge i_clk) begin
        cnt_a    <= (a_sd_read || a_sd_write) ? cnt_a + 1 : 0;
        a_sd_fin <= (a_sd_read || a_sd_write) && (lat_a != 0) && (cnt_a + 1 == lat_a);
        cnt_b    <= (b_sd_read || b_sd_write) ? cnt_b + 1 : 0;
        b_sd_fin <= (b_sd_read || b_sd_write) && (lat_b != 0) && (cnt_b + 1 == lat_b);
    end

    int           gq_a[$];
    int           gq_b[$];
    logic [N-1:0] a_gprev = '0;
    logic [N-1:0] b_gprev = '0;
    logic         a_wprev = 1'b0;
    int           wr_rise_a = 0;
    int           fin_tot_a = 0;
    always @(negedge i_clk) begin
        if (a_grant != '0 && a_gprev == '0) gq_a.push_back(onehot_idx(a_grant));
        if (b_grant != '0 && b_gprev == '0) gq_b.push_back(onehot_idx(b_grant));
        a_gprev <= a_grant;
        b_gprev <= b_grant;
        a_wprev <= a_sd_write;
        if (a_sd_write && !a_wprev) wr_rise_a <= wr_rise_a + 1;
        if (a_fin != '0) fin_tot_a <= fin_tot_a + 1;
    end

    logic [1:0]    f_strobe;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_wdata;
    logic [N-1:0]  f_grant, s_fin, s_err;
    logic          s_prevfin;
    int            hi_r, hi_w;
    int            rem_a[N];

    // One access on DUT a: idle gap, raise request, count strobe cycles until cli_finished.
    task automatic serve_one(input int k, input bit rd, input bit wr,
                             input logic [AW-1:0] adr, input logic [DW-1:0] wd);
        bit seen = 1'b0;
        @(negedge i_clk);
        a_addr[k*AW +: AW]  = adr;
        a_wdata[k*DW +: DW] = wd;
        a_read[k]  = rd;
        a_write[k] = wr;
        @(negedge i_clk);
        f_strobe = {a_sd_read, a_sd_write};
        f_addr   = a_sd_addr;
        f_wdata  = a_sd_wdata;
        f_grant  = a_grant;
        hi_r = int'(a_sd_read);
        hi_w = int'(a_sd_write);
        s_fin = '0; s_err = '0; s_prevfin = 1'b0;
        for (int c = 0; c < 64 && !seen; c++) begin
            @(negedge i_clk);
            if (a_fin != '0) begin
                seen = 1'b1; s_fin = a_fin; s_err = a_err; s_prevfin = a_sd_fin;
            end else begin
                hi_r += int'(a_sd_read);
                hi_w += int'(a_sd_write);
            end
        end
        a_read[k]  = 1'b0;
        a_write[k] = 1'b0;
    endtask

    // Clients on DUT a hold their strobes until rem_a[k] completions have been seen.
    task automatic run_a(input int budget);
        int left = 1;
        for (int c = 0; c < budget && left != 0; c++) begin
            @(negedge i_clk);
            left = 0;
            for (int k = 0; k < N; k++) begin
                if (a_fin[k] && rem_a[k] > 0) begin
                    rem_a[k]--;
                    if (rem_a[k] == 0) begin a_read[k] = 1'b0; a_write[k] = 1'b0; end
                end
                left += rem_a[k];
            end
        end
    endtask

    int exp2[6] = '{0, 1, 4, 0, 1, 4};
    int exp3[3] = '{1, 0, 3};

    initial begin
        int gs, ws, fs, tot;
        bit raised;
        logic [AW-1:0] t3_addr;
        a_read = '0; a_write = '0; a_addr = '0; a_wdata = '0; a_sd_rdata = '0;
        b_read = '0; b_write = '0; b_addr = '0; b_wdata = '0;
        for (int k = 0; k < N; k++) rem_a[k] = 0;
        repeat (3) @(negedge i_clk);
        check("rst_grant",  a_grant, 0);
        check("rst_busy",   a_busy, 0);
        check("rst_strobe", {a_sd_read, a_sd_write}, 0);
        check("rst_fin",    a_fin, 0);
        check("rst_err",    a_err, 0);
        check("rst_rdata",  a_rdata, 0);
        i_rst = 1'b0;

        // T1 single read, 5-cycle latency
        a_sd_rdata = 32'hDEAD_BEEF; lat_a = 5;
        serve_one(2, 1'b1, 1'b0, 23'h00010, 32'h0);
        check("t1_strobe", f_strobe, 2'b10);
        check("t1_addr",   f_addr, 23'h00010);
        check("t1_grant",  f_grant, 5'b00100);
        check("t1_hi",     hi_r, 5);
        check("t1_fin",    s_fin, 5'b00100);
        check("t1_err",    s_err, 0);
        check("t1_lat",    s_prevfin, 1);
        check("t1_rdata",  a_rdata, 32'hDEAD_BEEF);
        repeat (3) @(negedge i_clk);
        check("t1_no_reserve", {a_grant, a_busy}, 0);

        // T5 watchdog on a read, then a normal write
        lat_a = 0;
        serve_one(3, 1'b1, 1'b0, 23'h00033, 32'h0);
        check("t5_hi",    hi_r, 16);
        check("t5_fin",   s_fin, 5'b01000);
        check("t5_err",   s_err, 5'b01000);
        check("t5_rdata", a_rdata, 0);
        lat_a = 4;
        serve_one(1, 1'b0, 1'b1, 23'h00021, 32'h0000_CAFE);
        check("t5b_strobe", f_strobe, 2'b01);
        check("t5b_wdata",  f_wdata, 32'h0000_CAFE);
        check("t5b_hi_w",   hi_w, 4);
        check("t5b_fin",    s_fin, 5'b00010);
        check("t5b_err",    s_err, 0);
        check("t5b_rdata",  a_rdata, 0);

        // T4 read+write raised together: read only
        a_sd_rdata = 32'h1234_5678; lat_a = 3;
        serve_one(0, 1'b1, 1'b1, 23'h7, 32'hFFFF_FFFF);
        check("t4_strobe", f_strobe, 2'b10);
        check("t4_addr",   f_addr, 23'h7);
        check("t4_hi_w",   hi_w, 0);
        check("t4_hi_r",   hi_r, 3);
        check("t4_rdata",  a_rdata, 32'h1234_5678);

        // T2 round-robin, clients 0,1,4 hold writes from reset
        @(negedge i_clk);
        i_rst = 1'b1;
        a_sd_rdata = 32'hA5A5_A5A5; lat_a = 2;
        foreach (exp2[i]) if (i < 3) begin
            a_addr[exp2[i]*AW +: AW]  = AW'(exp2[i] * 32'h100);
            a_write[exp2[i]] = 1'b1;
            rem_a[exp2[i]]   = 2;
        end
        @(negedge i_clk);
        gs = gq_a.size(); ws = wr_rise_a;
        i_rst = 1'b0;
        run_a(200);
        tot = 0;
        for (int k = 0; k < N; k++) tot += rem_a[k];
        check("t2_remaining", tot, 0);
        check("t2_ngrants", gq_a.size() - gs, 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t2_grant%0d", i), (gs + i < gq_a.size()) ? gq_a[gs + i] : 99, exp2[i]);
        check("t2_nwrites", wr_rise_a - ws, 6);
        check("t2_rdata",   a_rdata, 0);

        // T6 reset during BUSY
        lat_a = 0;
        @(negedge i_clk);
        a_addr[3*AW +: AW] = 23'h66;
        a_read[3] = 1'b1;
        repeat (3) @(negedge i_clk);
        check("t6_busy", a_sd_read, 1);
        fs = fin_tot_a;
        a_read[0] = 1'b1;
        i_rst = 1'b1;
        #1;
        check("t6_rst_strobe", {a_sd_read, a_sd_write}, 0);
        check("t6_rst_grant",  a_grant, 0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("t6_first_grant", a_grant, 5'b00001);
        check("t6_no_finish",   fin_tot_a - fs, 0);
        a_read = '0;

        // T3 fixed priority: 1 and 3 together, 0 arrives during 1's access
        b_addr[1*AW +: AW] = 23'h111;
        gs = gq_b.size();
        raised = 1'b0; t3_addr = '0;
        @(negedge i_clk);
        b_read[1] = 1'b1; b_read[3] = 1'b1;
        for (int c = 0; c < 100 && (b_read != '0 || !raised); c++) begin
            @(negedge i_clk);
            if (!raised && b_grant == 5'b00010 && b_busy) begin
                b_read[0] = 1'b1; raised = 1'b1; t3_addr = b_sd_addr;
            end
            for (int k = 0; k < N; k++) if (b_fin[k]) b_read[k] = 1'b0;
        end
        check("t3_ngrants", gq_b.size() - gs, 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t3_grant%0d", i), (gs + i < gq_b.size()) ? gq_b[gs + i] : 99, exp3[i]);
        check("t3_addr",  t3_addr, 23'h111);
        check("t3_rdata", b_rdata, 32'h0BAD_F00D);
        check("t3_wdata", b_sd_wdata, 0);
        check("t3_err",   b_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire
